// File: rtl/onchip_mem_arb_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int BE_W       = 4;
  localparam int RD_LATENCY = 1;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a contested cycle goes
// to the requester that was not granted last.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    gnt_id = (last_grant == REQ0) ? REQ1 : REQ0;
    gnt    = 2'b00;
    case (req)
      2'b01:   gnt_id = REQ0;
      2'b10:   gnt_id = REQ1;
      default: ;
    endcase
    if (req != 2'b00) gnt = (gnt_id == REQ1) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM
// requesters; tracks the one-cycle read latency and routes returns.
module onchip_mem_arbiter #(
  parameter int ADDR_W = onchip_mem_arb_pkg::ADDR_W,
  parameter int DATA_W = onchip_mem_arb_pkg::DATA_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] r0_address,
  input  logic [BE_W-1:0]   r0_byteenable,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic              r0_waitrequest,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,

  input  logic [ADDR_W-1:0] r1_address,
  input  logic [BE_W-1:0]   r1_byteenable,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  import onchip_mem_arb_pkg::*;

  logic [1:0] active;
  logic [1:0] req;
  logic [1:0] gnt;
  req_id_t    gnt_id;
  req_id_t    last_grant;
  req_id_t    rd_owner;
  logic       rd_pend;
  logic       granted;
  logic       sel_write;

  assign active = {r1_read | r1_write, r0_read | r0_write};
  // Nothing is granted while reset is held, so no access reaches the RAM.
  assign req    = active & {2{reset_n}};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign granted   = |gnt;
  assign sel_write = (gnt_id == REQ1) ? r1_write : r0_write;

  assign mem_address    = (gnt_id == REQ1) ? r1_address    : r0_address;
  assign mem_byteenable = (gnt_id == REQ1) ? r1_byteenable : r0_byteenable;
  assign mem_writedata  = (gnt_id == REQ1) ? r1_writedata  : r0_writedata;
  assign mem_chipselect = granted;
  assign mem_write      = granted & sel_write;
  assign mem_clken      = 1'b1;

  assign r0_waitrequest = ~reset_n | (active[0] & ~gnt[0]);
  assign r1_waitrequest = ~reset_n | (active[1] & ~gnt[1]);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous, checked inside the edge.
    if (!reset_n) begin
      last_grant <= REQ1;
      rd_pend    <= 1'b0;
      rd_owner   <= REQ0;
    end else begin
      if (granted) last_grant <= gnt_id;
      rd_pend <= granted & ~sel_write;
      if (granted && !sel_write) rd_owner <= gnt_id;
    end
  end

  // Return routing uses the registered owner; a read pending at the reset
  // edge is squashed so no stale valid escapes during reset.
  assign r0_readdata      = mem_readdata;
  assign r1_readdata      = mem_readdata;
  assign r0_readdatavalid = reset_n & rd_pend & (rd_owner == REQ0);
  assign r1_readdatavalid = reset_n & rd_pend & (rd_owner == REQ1);

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 16384x32 RAM.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] r0_address, r1_address;
  logic [3:0]  r0_byteenable, r1_byteenable;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_writedata, r1_writedata;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  logic        pre_en = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] ram [16384];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .r0_address(r0_address), .r0_byteenable(r0_byteenable), .r0_read(r0_read),
    .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
    .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_byteenable(r1_byteenable), .r1_read(r1_read),
    .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
    .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // RAM model: registered read, byte-lane write; pre_en is a backdoor load.
  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic idle();
    r0_read = 0; r0_write = 0; r0_address = '0; r0_byteenable = 4'hF; r0_writedata = '0;
    r1_read = 0; r1_write = 0; r1_address = '0; r1_byteenable = 4'hF; r1_writedata = '0;
  endtask

  task automatic drive(input int id, input logic rd, input logic wr, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (id == 0) begin
      r0_read = rd; r0_write = wr; r0_address = a; r0_byteenable = be; r0_writedata = d;
    end else begin
      r1_read = rd; r1_write = wr; r1_address = a; r1_byteenable = be; r1_writedata = d;
    end
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk); pre_en = 1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_en = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset_n = 0; idle();
    @(negedge clk);
    @(negedge clk); reset_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 0;
    drive(0, 1, 0, 14'h0001, 4'hF, 32'h0);
    drive(1, 0, 1, 14'h0002, 4'hF, 32'h1234);
    @(negedge clk); #1;
    vectors++;
    if ({r0_waitrequest, r1_waitrequest} !== 2'b11) begin
      miscompares++; $display("FAIL reset_wait got=%b exp=11", {r0_waitrequest, r1_waitrequest});
    end
    vectors++;
    if ({mem_chipselect, mem_write} !== 2'b00) begin
      miscompares++; $display("FAIL reset_mem got cs/wr=%b exp=00", {mem_chipselect, mem_write});
    end
    vectors++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      miscompares++; $display("FAIL reset_valid got=%b exp=00", {r0_readdatavalid, r1_readdatavalid});
    end
    vectors++;
    if (mem_clken !== 1'b1) begin
      miscompares++; $display("FAIL clken got=%b exp=1", mem_clken);
    end
    idle();
    @(negedge clk); reset_n = 1;
  endtask

  task automatic test_single_read();
    @(negedge clk); drive(0, 1, 0, 14'h0010, 4'hF, 32'h0); #1;
    vectors++;
    if (r0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0 ||
        mem_address !== 14'h0010) begin
      miscompares++;
      $display("FAIL single_issue got wait=%b cs=%b wr=%b addr=%h exp 0 1 0 0010",
               r0_waitrequest, mem_chipselect, mem_write, mem_address);
    end
    @(negedge clk); idle(); #1;
    vectors++;
    if (r0_readdatavalid !== 1'b1 || r0_readdata !== 32'hDEADBEEF || r1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_return got v0=%b d=%h v1=%b exp 1 deadbeef 0",
               r0_readdatavalid, r0_readdata, r1_readdatavalid);
    end
    @(negedge clk); #1;
    vectors++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      miscompares++; $display("FAIL single_valid_clear got=%b exp=00", {r0_readdatavalid, r1_readdatavalid});
    end
  endtask

  task automatic test_contention();
    apply_reset();
    @(negedge clk);
    drive(0, 1, 0, 14'h0020, 4'hF, 32'h0);
    drive(1, 1, 0, 14'h0021, 4'hF, 32'h0); #1;
    vectors++;
    if (r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1 || mem_address !== 14'h0020) begin
      miscompares++;
      $display("FAIL contend_first got w0=%b w1=%b addr=%h exp 0 1 0020",
               r0_waitrequest, r1_waitrequest, mem_address);
    end
    @(negedge clk); drive(0, 0, 0, 14'h0, 4'hF, 32'h0); #1;
    vectors++;
    if (r1_waitrequest !== 1'b0 || mem_address !== 14'h0021 || r0_readdatavalid !== 1'b1 ||
        r0_readdata !== 32'h20202020 || r1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL contend_second got w1=%b addr=%h v0=%b d=%h v1=%b exp 0 0021 1 20202020 0",
               r1_waitrequest, mem_address, r0_readdatavalid, r0_readdata, r1_readdatavalid);
    end
    @(negedge clk); idle(); #1;
    vectors++;
    if (r1_readdatavalid !== 1'b1 || r1_readdata !== 32'h21212121 || r0_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL contend_return got v1=%b d=%h v0=%b exp 1 21212121 0",
               r1_readdatavalid, r1_readdata, r0_readdatavalid);
    end
  endtask

  task automatic test_fairness();
    int cnt0 = 0, cnt1 = 0, wait0 = 0, wait1 = 0, max_wait = 0;
    int prev = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(0, 1, 0, 14'h0020, 4'hF, 32'h0);
      drive(1, 1, 0, 14'h0021, 4'hF, 32'h0); #1;
      vectors++;
      if (r0_waitrequest !== ((i % 2) != 0) || r1_waitrequest !== ((i % 2) == 0)) begin
        miscompares++;
        $display("FAIL fair_grant cycle=%0d got w0=%b w1=%b exp winner r%0d",
                 i, r0_waitrequest, r1_waitrequest, i % 2);
      end
      if (prev >= 0) begin
        vectors++;
        if (r0_readdatavalid !== (prev == 0) || r1_readdatavalid !== (prev == 1) ||
            r0_readdata !== ((prev == 0) ? 32'h20202020 : 32'h21212121)) begin
          miscompares++;
          $display("FAIL fair_return cycle=%0d got v0=%b v1=%b d=%h exp owner r%0d",
                   i, r0_readdatavalid, r1_readdatavalid, r0_readdata, prev);
        end
      end
      if (!r0_waitrequest) begin cnt0++; wait0 = 0; end else wait0++;
      if (!r1_waitrequest) begin cnt1++; wait1 = 0; end else wait1++;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait1 > max_wait) max_wait = wait1;
      prev = i % 2;
    end
    vectors++;
    if (cnt0 != 4 || cnt1 != 4 || max_wait > 1) begin
      miscompares++;
      $display("FAIL fair_totals got g0=%0d g1=%0d max_wait=%0d exp 4 4 <=1", cnt0, cnt1, max_wait);
    end
    @(negedge clk); idle(); #1;
    vectors++;
    if (r1_readdatavalid !== 1'b1 || r0_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL fair_last got v0=%b v1=%b exp 0 1", r0_readdatavalid, r1_readdatavalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h20202020; exp_d[1] = 32'h21212121; exp_d[2] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive(0, 1, 0, (i == 2) ? 14'h0010 : 14'h0020 + 14'(i), 4'hF, 32'h0);
      else idle();
      #1;
      if (i < 3) begin
        vectors++;
        if (r0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_issue cycle=%0d got wait=%b cs=%b exp 0 1", i, r0_waitrequest, mem_chipselect);
        end
      end
      if (i > 0) begin
        vectors++;
        if (r0_readdatavalid !== 1'b1 || r0_readdata !== exp_d[i-1]) begin
          miscompares++;
          $display("FAIL b2b_return cycle=%0d got v=%b d=%h exp 1 %h",
                   i, r0_readdatavalid, r0_readdata, exp_d[i-1]);
        end
      end
    end
  endtask

  task automatic test_byte_write();
    @(negedge clk); drive(1, 0, 1, 14'h0030, 4'b0101, 32'h11223344); #1;
    vectors++;
    if (r1_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_byteenable !== 4'b0101 ||
        mem_writedata !== 32'h11223344) begin
      miscompares++;
      $display("FAIL bwrite_issue got wait=%b wr=%b be=%b wd=%h exp 0 1 0101 11223344",
               r1_waitrequest, mem_write, mem_byteenable, mem_writedata);
    end
    @(negedge clk); drive(1, 1, 0, 14'h0030, 4'hF, 32'h0); #1;
    vectors++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL bwrite_noresp got v=%b wr=%b exp 00 0", {r0_readdatavalid, r1_readdatavalid}, mem_write);
    end
    @(negedge clk); idle(); #1;
    vectors++;
    if (r1_readdatavalid !== 1'b1 || r1_readdata !== 32'hAA22CC44 || r0_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL bwrite_readback got v1=%b d=%h v0=%b exp 1 aa22cc44 0",
               r1_readdatavalid, r1_readdata, r0_readdatavalid);
    end
  endtask

  task automatic test_read_write();
    @(negedge clk); drive(0, 1, 1, 14'h0040, 4'hF, 32'h5A5A5A5A); #1;
    vectors++;
    if (r0_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_address !== 14'h0040) begin
      miscompares++;
      $display("FAIL rw_issue got wait=%b wr=%b addr=%h exp 0 1 0040", r0_waitrequest, mem_write, mem_address);
    end
    @(negedge clk); drive(0, 1, 0, 14'h0040, 4'hF, 32'h0); #1;
    vectors++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      miscompares++; $display("FAIL rw_novalid got=%b exp=00", {r0_readdatavalid, r1_readdatavalid});
    end
    @(negedge clk); idle(); #1;
    vectors++;
    if (r0_readdatavalid !== 1'b1 || r0_readdata !== 32'h5A5A5A5A) begin
      miscompares++;
      $display("FAIL rw_readback got v=%b d=%h exp 1 5a5a5a5a", r0_readdatavalid, r0_readdata);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); drive(0, 1, 0, 14'h0010, 4'hF, 32'h0); #1;
    vectors++;
    if (r0_waitrequest !== 1'b0) begin
      miscompares++; $display("FAIL midrst_issue got wait=%b exp 0", r0_waitrequest);
    end
    @(negedge clk); reset_n = 0;
    drive(0, 1, 0, 14'h0010, 4'hF, 32'h0);
    drive(1, 1, 0, 14'h0021, 4'hF, 32'h0); #1;
    vectors++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00 || {r0_waitrequest, r1_waitrequest} !== 2'b11 ||
        mem_chipselect !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_hold got v=%b w=%b cs=%b exp 00 11 0",
               {r0_readdatavalid, r1_readdatavalid}, {r0_waitrequest, r1_waitrequest}, mem_chipselect);
    end
    @(negedge clk); #1;
    vectors++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      miscompares++; $display("FAIL midrst_valid got=%b exp=00", {r0_readdatavalid, r1_readdatavalid});
    end
    @(negedge clk); reset_n = 1; #1;
    vectors++;
    if (r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1 || {r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_lastgrant got w0=%b w1=%b v=%b exp 0 1 00",
               r0_waitrequest, r1_waitrequest, {r0_readdatavalid, r1_readdatavalid});
    end
    @(negedge clk); idle(); #1;
    vectors++;
    if (r0_readdatavalid !== 1'b1 || r0_readdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL midrst_reissue got v=%b d=%h exp 1 deadbeef", r0_readdatavalid, r0_readdata);
    end
  endtask

  initial begin
    reset_n = 0;
    idle();
    preload(14'h0010, 32'hDEADBEEF);
    preload(14'h0020, 32'h20202020);
    preload(14'h0021, 32'h21212121);
    preload(14'h0030, 32'hAABBCCDD);
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_byte_write();
    test_read_write();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master round-robin arbiter that shares the single-port 16384×32 on-chip RAM between two Avalon-MM requesters, for example the HPS bridge and the fabric adder datapath. It sits between the requesters and the RAM's slave port. It issues at most one access per cycle, tracks the one-cycle read latency, and routes read data back to the requester that owns it.

## Interface
Parameters:
- ADDR_W, 14, word address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width
- BE_W, DATA_W/8, byteenable width

Ports (x ∈ {0,1}):
- clk  in  1  single clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- rx_address  in  ADDR_W  requester x word address
- rx_byteenable  in  BE_W  requester x byte lanes
- rx_read  in  1  requester x read request
- rx_write  in  1  requester x write request
- rx_writedata  in  DATA_W  requester x write data
- rx_waitrequest  out  1  high = request not accepted this cycle
- rx_readdata  out  DATA_W  read data to requester x
- rx_readdatavalid  out  1  rx_readdata valid this cycle
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; constant 1
- mem_readdata  in  DATA_W  from RAM readdata; valid 1 cycle after a read is issued

## Operation
- Requester x is active when rx_read | rx_write. If both are high, the access is a write and the read is ignored.
- Grant logic is combinational in the same cycle:
  - Only one requester active: it wins.
  - Both active: the requester not granted last wins.
  - Neither active: no grant; mem_chipselect=0, mem_write=0.
- last_grant register: updated to the winner on every granted cycle and held otherwise. Reset value is 1, so r0 wins the first contested cycle.
- Winner: rx_waitrequest=0. mem_* carry the winner's address, byteenable and writedata. mem_chipselect=1. mem_write=rx_write.
- Loser: rx_waitrequest=1 while active. It must hold its signals stable (Avalon rule).
- Inactive requester: rx_waitrequest=0.
- Read tracking registers:
  - rd_pend is set for one cycle after a granted read.
  - rd_owner records the winner of that read.
  - While rd_pend is high, r[rd_owner]_readdatavalid=1 and r[rd_owner]_readdata=mem_readdata.
  - The other requester's readdatavalid=0.
- rx_readdata is driven from mem_readdata to both requesters at all times; only readdatavalid qualifies it.
- A back-to-back read by one requester, or alternating reads by the two requesters, sustains 1 access/cycle. The return for access N coincides with the issue of access N+1.
- Fairness: under continuous requests from both, grants strictly alternate. The maximum wait is 1 cycle.

## Timing
- Reset (reset_n=0 at an edge):
  - last_grant=1, rd_pend=0.
  - All rx_readdatavalid=0.
  - mem_chipselect and mem_write are forced to 0.
  - rx_waitrequest=1 for both requesters during reset.
- Reset mid-operation: a pending read is discarded and no readdatavalid is produced. Requesters must reissue.
- Read latency, request to readdatavalid: 1 cycle after the accepting edge.
- Write: completes at the accepting edge. No response.
- A write followed next cycle by a read to the same address returns the new data (RAM read-during-write is not exercised across cycles).
- Simultaneous read return and new grant: independent. Return routing uses registered rd_owner, not the current grant.

## Structure
- Package onchip_mem_arb_pkg contains:
  - constants ADDR_W=14, DATA_W=32, BE_W=4, RD_LATENCY=1
  - typedef req_id_t (1 bit; REQ0, REQ1)
- Sub-module rr_arb2: purely the 2-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt[1:0], gnt_id.
- Top level holds last_grant, the read tracking registers and the muxes.

## Test plan
- Reset then single read: r0_read at addr 0x0010, RAM preloaded with 0xDEADBEEF → r0_waitrequest=0 that cycle; next cycle r0_readdatavalid=1, r0_readdata=0xDEADBEEF; r1_readdatavalid=0.
- Contention from reset: r0 and r1 both read in the same cycle → r0 granted first, r1 waitrequest=1. Next cycle r1 granted. Valids follow in order r0, r1.
- Continuous dual requests for 8 cycles → grants alternate r0,r1,r0,… (4 each), and no request waits more than 1 cycle.
- Byte write: r1 writes 0x11223344 with byteenable 0b0101 to a word holding 0xAABBCCDD, then reads it back → readdata 0xAA22CC44 delivered to r1 only.
- Read+write both high on r0: write of 0x5A5A5A5A → memory updated and no readdatavalid generated.
- Reset mid-read: reset_n=0 in the cycle after the read is accepted → readdatavalid stays 0, last_grant returns to 1, and both waitrequest=1 while in reset.
